// File: rtl/sha3_pkg.sv
// sha3_pkg: shared Keccak geometry, lane/state types and squeeze FSM encoding.
package sha3_pkg;
  localparam int LANE_W = 64;
  localparam int NUM_LANES = 25;
  localparam int STATE_W = 1600;
  typedef logic [LANE_W-1:0] lane_t;
  typedef lane_t [NUM_LANES-1:0] state_t;
  typedef enum logic [1:0] {IDLE, EMIT, WAIT_PERM} squeeze_state_e;
  function automatic int mod5(input int v);
    return ((v % 5) + 5) % 5;
  endfunction
  function automatic int lane_index(input int x, input int y);
    return mod5(x) + 5 * mod5(y);
  endfunction
endpackage

// File: rtl/squeeze_lane_mux.sv
// squeeze_lane_mux: selects one 64-bit lane of the rate buffer; out-of-range index yields zero.
module squeeze_lane_mux import sha3_pkg::*; #(
  parameter int RATE_LANES = 17,
  parameter int IDX_W = 5
) (
  input  lane_t [RATE_LANES-1:0] i_lanes,
  input  logic  [IDX_W-1:0]      i_idx,
  output lane_t                  o_lane
);
  always_comb begin
    o_lane = '0;
    for (int k = 0; k < RATE_LANES; k++)
      if (i_idx == IDX_W'(k)) o_lane = i_lanes[k];
  end
endmodule

// File: rtl/keccak_squeeze.sv
// keccak_squeeze: streams the rate lanes of a permuted Keccak state as 64-bit words,
// requesting further permutations until the requested word count is delivered.
module keccak_squeeze import sha3_pkg::*; #(
  parameter int RATE_LANES = 17
) (
  input  logic        clk,
  input  logic        rst_n,
  input  state_t      state_i,
  input  logic        state_valid_i,
  output logic        state_ready_o,
  input  logic [15:0] len_i,
  output logic        perm_req_o,
  output logic [63:0] out_data_o,
  output logic        out_valid_o,
  input  logic        out_ready_i,
  output logic        out_last_o,
  output logic        busy_o
);
  localparam int IDX_W = (RATE_LANES > 1) ? $clog2(RATE_LANES) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(RATE_LANES - 1);

  squeeze_state_e r_state, w_next;
  logic [15:0] r_rem;
  logic [IDX_W-1:0] r_idx;
  lane_t [RATE_LANES-1:0] r_buf;
  logic r_perm_req;
  logic w_hs, w_load, w_to_perm;
  lane_t w_lane;

  assign state_ready_o = (r_state != EMIT);
  assign busy_o = (r_state != IDLE);
  assign out_valid_o = (r_state == EMIT);
  assign out_last_o = out_valid_o && (r_rem == 16'd1);
  assign out_data_o = w_lane;
  assign perm_req_o = r_perm_req;

  squeeze_lane_mux #(.RATE_LANES(RATE_LANES), .IDX_W(IDX_W)) u_mux (
    .i_lanes(r_buf),
    .i_idx(r_idx),
    .o_lane(w_lane)
  );

  always_comb begin
    w_next = r_state;
    w_hs = out_valid_o && out_ready_i;
    w_load = state_ready_o && state_valid_i;
    w_to_perm = w_hs && (r_rem != 16'd1) && (r_idx == LAST_IDX);
    if (w_load && (r_state == WAIT_PERM || len_i != 16'd0)) w_next = EMIT;
    else if (w_hs && r_rem == 16'd1) w_next = IDLE;
    else if (w_to_perm) w_next = WAIT_PERM;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) r_state <= IDLE;
    else r_state <= w_next;

  // remaining is only reloaded by a fresh request; a re-permuted state continues the count
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rem <= '0;
      r_idx <= '0;
      r_buf <= '0;
      r_perm_req <= 1'b0;
    end else begin
      r_perm_req <= w_to_perm;
      if (w_load) begin
        r_buf <= state_i[RATE_LANES-1:0];
        r_idx <= '0;
      end else if (w_hs && r_idx != LAST_IDX) r_idx <= r_idx + 1'b1;
      if (w_load && r_state == IDLE) r_rem <= len_i;
      else if (w_hs) r_rem <= r_rem - 1'b1;
    end
  end
endmodule

// File: tb/tb_keccak_squeeze.sv
// tb_keccak_squeeze: scoreboard bench; expected words are queued at stimulus time
// and checked against every valid output cycle, stalled or not.
module tb_keccak_squeeze;
  localparam int RL = 21;
  typedef struct { logic [63:0] d; logic l; } exp_t;

  logic clk = 1'b0, rst_n = 1'b0;
  logic [1599:0] state_i = '0;
  logic state_valid_i = 1'b0, out_ready_i = 1'b1;
  logic [15:0] len_i = '0;
  logic state_ready_o, perm_req_o, out_valid_o, out_last_o, busy_o;
  logic [63:0] out_data_o;
  exp_t exp_q[$];
  int n_tests = 0, n_fail = 0, perm_cnt = 0;
  bit tog = 1'b0;

  keccak_squeeze #(.RATE_LANES(RL)) dut (
    .clk(clk), .rst_n(rst_n), .state_i(state_i), .state_valid_i(state_valid_i),
    .state_ready_o(state_ready_o), .len_i(len_i), .perm_req_o(perm_req_o),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .out_last_o(out_last_o), .busy_o(busy_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [1599:0] mk(input int m);
    logic [1599:0] s;
    for (int i = 0; i < 25; i++)
      s[64*i +: 64] = (m == 0) ? {16{4'(i)}} :
                      (m == 1) ? ~64'(i) : {32'(i * 3 + 1), 32'hC0DE_0000 | 32'(i)};
    return s;
  endfunction

  task automatic push(input logic [1599:0] s, input int n, input bit last_on_final);
    for (int k = 0; k < n; k++) begin
      exp_t e;
      e.d = s[64*k +: 64];
      e.l = last_on_final && (k == n - 1);
      exp_q.push_back(e);
    end
  endtask

  task automatic send(input logic [1599:0] s, input logic [15:0] len, input bit exp_valid);
    bit ok = 1'b0;
    @(posedge clk); #1;
    state_i = s; len_i = len; state_valid_i = 1'b1;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = state_ready_o;
    end
    chk("accept_timeout", 64'(ok), 64'd1);
    @(posedge clk); #1;
    state_valid_i = 1'b0;
    chk("latency_valid", 64'(out_valid_o), 64'(exp_valid));
  endtask

  task automatic wait_idle();
    bit ok = 1'b0;
    for (int c = 0; c < 400 && !ok; c++) begin
      @(negedge clk);
      ok = !busy_o && exp_q.size() == 0;
    end
    chk("idle_timeout", 64'(ok), 64'd1);
  endtask

  always @(negedge clk) begin
    if (rst_n && perm_req_o) perm_cnt++;
    if (rst_n && out_valid_o) begin
      if (exp_q.size() == 0) chk("unexpected_word", out_data_o, 64'hX);
      else begin
        chk("data", out_data_o, exp_q[0].d);
        chk("last", 64'(out_last_o), 64'(exp_q[0].l));
        if (out_ready_i) void'(exp_q.pop_front());
      end
    end
  end

  initial forever begin
    @(posedge clk); #1;
    out_ready_i = tog ? ~out_ready_i : 1'b1;
  end

  initial begin
    bit ok;
    #2;
    chk("rst_valid", 64'(out_valid_o), 64'd0);
    chk("rst_last", 64'(out_last_o), 64'd0);
    chk("rst_perm", 64'(perm_req_o), 64'd0);
    chk("rst_busy", 64'(busy_o), 64'd0);
    chk("rst_data", out_data_o, 64'd0);
    chk("rst_ready", 64'(state_ready_o), 64'd1);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    push(mk(0), 4, 1'b1);
    send(mk(0), 16'd4, 1'b1);
    wait_idle();
    chk("t1_no_perm", 64'(perm_cnt), 64'd0);
    chk("t1_ready", 64'(state_ready_o), 64'd1);

    tog = 1'b1;
    push(mk(0), 4, 1'b1);
    send(mk(0), 16'd4, 1'b1);
    wait_idle();
    tog = 1'b0;

    push(mk(2), RL, 1'b0);
    push(mk(1), 2, 1'b1);
    send(mk(2), 16'(RL + 2), 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 200 && !ok; c++) begin
      @(negedge clk);
      ok = perm_req_o;
    end
    chk("perm_seen", 64'(ok), 64'd1);
    chk("perm_ready", 64'(state_ready_o), 64'd1);
    chk("perm_words_left", 64'(exp_q.size()), 64'd2);
    @(negedge clk);
    chk("perm_one_cycle", 64'(perm_req_o), 64'd0);
    chk("perm_wait_valid", 64'(out_valid_o), 64'd0);
    send(mk(1), 16'd0, 1'b1);
    wait_idle();
    chk("perm_count", 64'(perm_cnt), 64'd1);

    send(mk(2), 16'd0, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk("len0_valid", 64'(out_valid_o), 64'd0);
      chk("len0_busy", 64'(busy_o), 64'd0);
    end

    push(mk(0), 4, 1'b1);
    send(mk(0), 16'd4, 1'b1);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(posedge clk);
      ok = exp_q.size() == 2;
    end
    chk("rst_mid_reach", 64'(ok), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    chk("rst_mid_valid", 64'(out_valid_o), 64'd0);
    chk("rst_mid_ready", 64'(state_ready_o), 64'd1);
    chk("rst_mid_busy", 64'(busy_o), 64'd0);
    exp_q.delete();
    @(posedge clk); #1 rst_n = 1'b1;
    push(mk(2), 4, 1'b1);
    send(mk(2), 16'd4, 1'b1);
    wait_idle();

    push(mk(2), 4, 1'b1);
    push(mk(1), 2, 1'b1);
    @(posedge clk); #1;
    state_i = mk(2); len_i = 16'd4; state_valid_i = 1'b1;
    @(posedge clk); #1;
    state_i = mk(1); len_i = 16'd2;
    @(negedge clk);
    chk("hold_ready_low", 64'(state_ready_o), 64'd0);
    ok = 1'b0;
    for (int c = 0; c < 50 && !ok; c++) begin
      @(negedge clk);
      ok = state_ready_o;
    end
    chk("hold_reach_idle", 64'(ok), 64'd1);
    chk("hold_words_left", 64'(exp_q.size()), 64'd2);
    @(posedge clk); #1 state_valid_i = 1'b0;
    wait_idle();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
